// File: rtl/relu_wb_if.sv
// Output beat channel of the ReLU write-back sequencer.
// Carries valid/ready handshake, lane data and last-beat flag.
interface relu_wb_if #(
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/relu_wb_sequencer.sv
// Snapshots accumulator lanes and streams them through ReLU/bypass.
// Counts negative lanes per completed job.
module relu_wb_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 16,
  parameter int SEL_W     = $clog2(NUM_LANES),
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [CNT_W-1:0]            lane_count_i,
  input  logic                        relu_en_i,
  input  logic [NUM_LANES*DATA_W-1:0] lanes_in_i,
  relu_wb_if.master                   wb,
  output logic [SEL_W-1:0]            sel_mux_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [CNT_W-1:0]            neg_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              idx_q, idx_d;
  logic [NUM_LANES*DATA_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]              cmax_q, cmax_d;
  logic                          mode_q, mode_d;
  logic [CNT_W-1:0]              acc_q, acc_d;
  logic [CNT_W-1:0]              negc_q, negc_d;

  logic [DATA_W-1:0] lane_w [NUM_LANES];
  logic [DATA_W-1:0] cur_w;
  logic [CNT_W-1:0]  eff_cnt;
  logic              run_w;
  logic              last_w;
  logic              xfer_w;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_w[k] = buf_q[k*DATA_W +: DATA_W];
  end

  assign cur_w  = lane_w[idx_q];
  assign run_w  = (state_q == S_RUN);
  assign last_w = run_w && (CNT_W'(idx_q) == cmax_q - CNT_W'(1));
  assign xfer_w = run_w && wb.out_ready;

  // Zero and oversized counts both mean "all lanes".
  assign eff_cnt =
    (lane_count_i == '0 ||
     lane_count_i > CNT_W'(NUM_LANES)) ?
    CNT_W'(NUM_LANES) : lane_count_i;

  assign wb.out_valid = run_w;
  assign wb.out_last  = last_w;
  assign wb.out_data  =
    (mode_q && cur_w[DATA_W-1]) ? '0 : cur_w;
  assign sel_mux_o    = idx_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign neg_count_o  = negc_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cmax_d  = cmax_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    negc_d  = negc_q;
    if (clear_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            buf_d   = lanes_in_i;
            mode_d  = relu_en_i;
            cmax_d  = eff_cnt;
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (xfer_w) begin
            acc_d = acc_q + CNT_W'(cur_w[DATA_W-1]);
            if (last_w) begin
              state_d = S_DONE;
              negc_d  = acc_d;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      cmax_q  <= CNT_W'(NUM_LANES);
      mode_q  <= 1'b0;
      acc_q   <= '0;
      negc_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cmax_q  <= cmax_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      negc_q  <= negc_d;
    end
  end

endmodule

// File: tb/tb_relu_wb_sequencer.sv
// Self-checking bench for relu_wb_sequencer.
// Random jobs compared against a per-job expected-beat model.
module tb_relu_wb_sequencer;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, clear, relu_en;
  logic [CW-1:0] lane_count;
  logic [NL*DW-1:0] lanes_in;
  logic [SW-1:0] sel_mux;
  logic          busy, done;
  logic [CW-1:0] neg_count;

  int tests = 0;
  int fails = 0;
  int last_neg = 0;

  relu_wb_if #(.DATA_W(DW)) wb ();

  relu_wb_sequencer #(.NUM_LANES(NL), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .clear_i      (clear),
    .lane_count_i (lane_count),
    .relu_en_i    (relu_en),
    .lanes_in_i   (lanes_in),
    .wb           (wb.master),
    .sel_mux_o    (sel_mux),
    .busy_o       (busy),
    .done_o       (done),
    .neg_count_o  (neg_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NL*DW-1:0] pack4(
    input int a, input int b, input int c, input int d);
    logic [DW-1:0] v0, v1, v2, v3;
    v0 = DW'(a); v1 = DW'(b); v2 = DW'(c); v3 = DW'(d);
    return {v3, v2, v1, v0};
  endfunction

  // Runs one job; stall_len cycles of out_ready=0 are inserted
  // while beat stall_beat is presented. rnd randomises out_ready.
  task automatic do_job(
    input logic [NL*DW-1:0] lanes, input int lc, input bit relu,
    input int stall_beat, input int stall_len, input bit rnd,
    input bit disturb, output int run_cycles);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v;
    int eff, negs, beat, stalled, guard;
    bit rdy;
    logic [SW+DW+2-1:0] got, want;
    eff = (lc == 0 || lc > NL) ? NL : lc;
    negs = 0;
    for (int k = 0; k < eff; k++) begin
      v = lanes[k*DW +: DW];
      if ($signed(v) < 0) negs++;
      exp_q.push_back((relu && $signed(v) < 0) ? '0 : v);
    end
    @(negedge clk);
    start = 1; lanes_in = lanes;
    lane_count = CW'(lc); relu_en = relu; wb.out_ready = 0;
    @(negedge clk);
    start = 0;
    beat = 0; stalled = 0; guard = 0; run_cycles = 0;
    while (beat < eff && guard < 200) begin
      want = {1'b1, SW'(beat), exp_q[beat], beat == eff - 1};
      got  = {wb.out_valid, sel_mux, wb.out_data, wb.out_last};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL beat%0d got=%h want=%h", beat, got, want);
      end
      if (rnd) rdy = 1'($urandom_range(0, 1));
      else if (beat == stall_beat && stalled < stall_len) begin
        rdy = 0; stalled++;
      end else rdy = 1;
      wb.out_ready = rdy;
      if (disturb) begin
        start = 1; lanes_in = {$urandom, $urandom};
        lane_count = CW'($urandom_range(1, 2));
        relu_en = ~relu;
      end
      run_cycles++; guard++;
      @(negedge clk);
      if (rdy) beat++;
    end
    tests++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL job_timeout beats=%0d want=%0d", beat, eff);
    end
    wb.out_ready = 0;
    tests++;
    if ({done, busy, wb.out_valid, neg_count} !== {3'b110, CW'(negs)}) begin
      fails++;
      $display("FAIL done_state d=%b b=%b v=%b neg=%0d want neg=%0d",
               done, busy, wb.out_valid, neg_count, negs);
    end
    @(negedge clk);
    start = 0;
    tests++;
    if ({done, busy, neg_count} !== {2'b00, CW'(negs)}) begin
      fails++;
      $display("FAIL after_done d=%b b=%b neg=%0d want 0,0,%0d",
               done, busy, neg_count, negs);
    end
    last_neg = negs;
  endtask

  task automatic test_reset();
    tests++;
    if ({wb.out_valid, busy, done, sel_mux, neg_count, wb.out_data,
         wb.out_last} !== '0) begin
      fails++;
      $display("FAIL reset v=%b b=%b d=%b sel=%0d neg=%0d data=%h l=%b",
               wb.out_valid, busy, done, sel_mux, neg_count,
               wb.out_data, wb.out_last);
    end
  endtask

  task automatic test_basic_relu();
    int rc;
    do_job(pack4(5, -3, 7, -1), 4, 1, -1, 0, 0, 0, rc);
    tests++;
    if (rc != 4) begin
      fails++; $display("FAIL basic_run_cycles got=%0d want=4", rc);
    end
  endtask

  task automatic test_bypass_partial();
    int rc;
    do_job(pack4(-2, 9, -8, 4), 2, 0, -1, 0, 0, 0, rc);
    tests++;
    if (rc != 2) begin
      fails++; $display("FAIL partial_run_cycles got=%0d want=2", rc);
    end
  endtask

  task automatic test_backpressure();
    int rc;
    do_job(pack4(5, -3, 7, -1), 4, 1, 1, 3, 0, 0, rc);
    tests++;
    if (rc != 7) begin
      fails++; $display("FAIL bp_run_cycles got=%0d want=7", rc);
    end
  endtask

  task automatic test_saturation();
    int rc;
    do_job(pack4(-9, 1, -2, 3), 0, 1, -1, 0, 0, 0, rc);
    tests++;
    if (rc != 4) begin
      fails++; $display("FAIL sat0_cycles got=%0d want=4", rc);
    end
    do_job(pack4(6, -6, 100, -32768), 7, 0, -1, 0, 0, 1, rc);
    tests++;
    if (rc != 4) begin
      fails++; $display("FAIL sat7_cycles got=%0d want=4", rc);
    end
  endtask

  task automatic test_abort();
    int rc;
    @(negedge clk);
    start = 1; lanes_in = pack4(-1, -1, -1, -1);
    lane_count = 4; relu_en = 1; wb.out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk); clear = 1; start = 1;
    @(negedge clk); clear = 0; start = 0; wb.out_ready = 0;
    tests++;
    if ({wb.out_valid, busy, done, sel_mux, neg_count} !==
        {3'b000, SW'(0), CW'(last_neg)}) begin
      fails++;
      $display("FAIL abort v=%b b=%b d=%b sel=%0d neg=%0d want neg=%0d",
               wb.out_valid, busy, done, sel_mux, neg_count, last_neg);
    end
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL abort_no_done b=%b d=%b want 00", busy, done);
    end
    do_job(pack4(3, -4, 0, 2), 3, 1, -1, 0, 0, 0, rc);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1; lanes_in = pack4(-1, -2, 3, 4);
    lane_count = 4; relu_en = 0; wb.out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++;
    if ({wb.out_valid, busy, done, sel_mux, neg_count} !== '0) begin
      fails++;
      $display("FAIL async_reset v=%b b=%b d=%b sel=%0d neg=%0d",
               wb.out_valid, busy, done, sel_mux, neg_count);
    end
    last_neg = 0;
    wb.out_ready = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_random();
    int rc;
    for (int j = 0; j < 25; j++) begin
      do_job({$urandom, $urandom}, $urandom_range(0, 7),
             1'($urandom_range(0, 1)), -1, 0, 1,
             1'($urandom_range(0, 1)), rc);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; clear = 0; relu_en = 0;
    lane_count = '0; lanes_in = '0; wb.out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_basic_relu();
    test_bypass_partial();
    test_backpressure();
    test_saturation();
    test_abort();
    test_async_reset();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
